// File: rtl/xpr_puf_ctrl.sv
// ============================================================================
// Module      : xpr_puf_ctrl
// Description : Sequencer for one XPR PUF/entropy slice. It evaluates one
//               response bit per challenge pair (reset, release, settle,
//               sample) and delivers the assembled word over valid/ready.
//               Optional macro XPR_PUF_MAJORITY_EN enables 3-way majority
//               voting per response bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xpr_puf_ctrl #(
    parameter int RESP_BITS     = 32,
    parameter int RESET_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2*RESP_BITS-1:0] challenge,
    output logic                   busy,
    output logic [RESP_BITS-1:0]   resp,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   slice_iR,
    output logic                   slice_i1,
    output logic                   slice_i2,
    input  logic                   slice_out1,
    input  logic                   slice_out2
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_EVAL   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [2*RESP_BITS-1:0] r_chal;
    logic [1:0]             r_sync1;
    logic [1:0]             r_sync2;

    logic                   w_sample;
    logic                   w_last;
    logic [IDX_W-1:0]       w_idx_next;
    logic [IDX_W:0]         w_pair_lo;
    logic [IDX_W:0]         w_pair_hi;
    logic                   w_final;
    logic                   w_res;

    assign w_sample   = r_sync1[1] ^ r_sync2[1];
    assign w_last     = (r_idx == IDX_LAST);
    assign w_idx_next = r_idx + 1'b1;
    assign w_pair_lo  = {w_idx_next, 1'b0};
    assign w_pair_hi  = {w_idx_next, 1'b1};

`ifdef XPR_PUF_MAJORITY_EN
    // r_rep counts completed evaluations of the current bit (0..2)
    logic [1:0] r_rep;
    logic [1:0] r_votes;
    logic [1:0] w_votes_sum;

    assign w_votes_sum = r_votes + {1'b0, w_sample};
    assign w_final     = (r_rep == 2'd2);
    assign w_res       = w_votes_sum[1];
`else
    assign w_final     = 1'b1;
    assign w_res       = w_sample;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_chal     <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            busy       <= 1'b0;
            resp       <= '0;
            resp_valid <= 1'b0;
            slice_iR   <= 1'b0;
            slice_i1   <= 1'b0;
            slice_i2   <= 1'b0;
`ifdef XPR_PUF_MAJORITY_EN
            r_rep      <= 2'd0;
            r_votes    <= 2'd0;
`endif
        end else begin
            r_sync1 <= {r_sync1[0], slice_out1};
            r_sync2 <= {r_sync2[0], slice_out2};

            case (r_state)
                S_IDLE: begin
                    slice_iR <= 1'b0;
                    if (start) begin
                        r_chal   <= challenge;
                        resp     <= '0;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        slice_i1 <= challenge[0];
                        slice_i2 <= challenge[1];
`ifdef XPR_PUF_MAJORITY_EN
                        r_rep    <= 2'd0;
                        r_votes  <= 2'd0;
`endif
                        r_state  <= S_RST;
                    end
                end

                S_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_cnt    <= '0;
                        slice_iR <= 1'b1;
                        r_state  <= S_EVAL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_EVAL: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_SAMPLE: begin
                    // iR drops on exit: both RST and DONE hold the slice in reset
                    r_cnt    <= '0;
                    slice_iR <= 1'b0;
`ifdef XPR_PUF_MAJORITY_EN
                    if (w_final) begin
                        r_rep   <= 2'd0;
                        r_votes <= 2'd0;
                    end else begin
                        r_rep   <= r_rep + 1'b1;
                        r_votes <= w_votes_sum;
                    end
`endif
                    if (!w_final) begin
                        r_state <= S_RST;
                    end else begin
                        resp[r_idx] <= w_res;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx    <= w_idx_next;
                            slice_i1 <= r_chal[w_pair_lo];
                            slice_i2 <= r_chal[w_pair_hi];
                            r_state  <= S_RST;
                        end
                    end
                end

                S_DONE: begin
                    slice_iR <= 1'b0;
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        resp_valid <= 1'b1;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    slice_iR <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xpr_puf_ctrl.sv
// ============================================================================
// Module      : tb_xpr_puf_ctrl
// Description : Directed self-checking bench for xpr_puf_ctrl (4-bit config).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xpr_puf_ctrl;

    localparam int RESP_BITS     = 4;
    localparam int RESET_CYCLES  = 2;
    localparam int SETTLE_CYCLES = 4;
    localparam int CNT_W         = 8;
`ifdef XPR_PUF_MAJORITY_EN
    localparam int MULT = 3;
`else
    localparam int MULT = 1;
`endif
    localparam int PER_EVAL = RESET_CYCLES + SETTLE_CYCLES + 1;
    localparam int E_DONE   = RESP_BITS * PER_EVAL * MULT;
    localparam int LATENCY  = E_DONE + 1;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [2*RESP_BITS-1:0] challenge = '0;
    logic                   busy;
    logic [RESP_BITS-1:0]   resp;
    logic                   resp_valid;
    logic                   resp_ready = 1'b0;
    logic                   slice_iR;
    logic                   slice_i1;
    logic                   slice_i2;
    logic                   slice_out1;
    logic                   slice_out2;

    int checks   = 0;
    int failures = 0;

    // Slice model: out1 follows i1, out2 is 0; in majority builds the
    // 2nd of every 3 evaluations sees out1 inverted.
    int   eval_cnt = 0;
    logic prev_ir  = 1'b0;
    logic flip;

    always @(posedge clock) begin
        if (reset) begin
            eval_cnt <= 0;
            prev_ir  <= 1'b0;
        end else begin
            prev_ir <= slice_iR;
            if (slice_iR && !prev_ir) eval_cnt <= eval_cnt + 1;
        end
    end

    always_comb flip = (MULT == 3) && ((eval_cnt % 3) == 2);
    assign slice_out1 = slice_i1 ^ flip;
    assign slice_out2 = 1'b0;

    xpr_puf_ctrl #(
        .RESP_BITS    (RESP_BITS),
        .RESET_CYCLES (RESET_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .challenge  (challenge),
        .busy       (busy),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .slice_iR   (slice_iR),
        .slice_i1   (slice_i1),
        .slice_i2   (slice_i2),
        .slice_out1 (slice_out1),
        .slice_out2 (slice_out2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] chal_a;
    int         p;
    int         b;
    int         lat;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp", 32'(resp), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_iR", 32'(slice_iR), 32'd0);
        check("rst_i1", 32'(slice_i1), 32'd0);
        check("rst_i2", 32'(slice_i2), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Full measurement with per-cycle waveform checks; a second start
        // with a different challenge arrives during bit 2 and must be ignored
        chal_a    = 8'b01_00_01_01;
        challenge = chal_a;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < E_DONE; e++) begin
            p = e % PER_EVAL;
            b = e / (PER_EVAL * MULT);
            check($sformatf("run_busy_e%0d", e), 32'(busy), 32'd1);
            check($sformatf("run_valid_e%0d", e), 32'(resp_valid), 32'd0);
            check($sformatf("run_iR_e%0d", e), 32'(slice_iR), (p >= RESET_CYCLES) ? 32'd1 : 32'd0);
            if (p < RESET_CYCLES + SETTLE_CYCLES) begin
                check($sformatf("run_i1_e%0d", e), 32'(slice_i1), 32'(chal_a[2*b]));
                check($sformatf("run_i2_e%0d", e), 32'(slice_i2), 32'(chal_a[2*b+1]));
            end
            if (e == 2 * PER_EVAL * MULT + 1) begin
                challenge = 8'hFF;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("done_iR", 32'(slice_iR), 32'd0);
        check("done_valid_first", 32'(resp_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        tick();
        check("lat_valid", 32'(resp_valid), 32'd1);
        check("resp_1011", 32'(resp), 32'hB);

        // Backpressure: resp stays stable, start pulses ignored
        for (int k = 0; k < 10; k++) begin
            start = k[0];
            tick();
            check($sformatf("hold_valid_%0d", k), 32'(resp_valid), 32'd1);
            check($sformatf("hold_resp_%0d", k), 32'(resp), 32'hB);
            check($sformatf("hold_busy_%0d", k), 32'(busy), 32'd1);
        end
        // Handshake with a simultaneous start, which must be ignored
        resp_ready = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        resp_ready = 1'b0;
        check("hs_valid", 32'(resp_valid), 32'd0);
        check("hs_busy", 32'(busy), 32'd0);
        check("hs_resp_kept", 32'(resp), 32'hB);
        tick();
        check("hs_start_ignored", 32'(busy), 32'd0);

        // Reset during EVAL of bit 1
        challenge = 8'b01_00_01_01;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (PER_EVAL * MULT + RESET_CYCLES) tick();
        check("pre_abort_iR", 32'(slice_iR), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_iR", 32'(slice_iR), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_resp", 32'(resp), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Fresh measurement with resp_ready already high
        resp_ready = 1'b1;
        challenge  = 8'b00_01_00_01;
        start      = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!resp_valid && lat < 400) begin
            tick();
            lat++;
        end
        check("fresh_latency", 32'(lat), 32'(LATENCY));
        check("fresh_resp_0101", 32'(resp), 32'h5);
        check("fresh_busy", 32'(busy), 32'd1);
        tick();
        check("fresh_valid_drop", 32'(resp_valid), 32'd0);
        check("fresh_busy_drop", 32'(busy), 32'd0);
        resp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xpr_puf_ctrl.md
Name: xpr_puf_ctrl

Overview:
- Sequencer for one XPR PUF/entropy slice (two cross-coupled XOR/AND ring pairs, iR release input, i1/i2 challenge inputs, out1/out2 race outputs).
- Latches a challenge word and evaluates one response bit per challenge pair: hold slice in reset, release, wait for settle, sample.
- Assembles the bits into a response word delivered over a valid/ready handshake.
- Sits between the slice instance and the memory-mapped entropy/PUF register block.

Parameters:
- RESP_BITS, 32: response width; the challenge is 2*RESP_BITS bits.
- RESET_CYCLES, 4: cycles iR is held low per evaluation; must be >= 1.
- SETTLE_CYCLES, 16: cycles iR is held high before sampling; must be >= 3 so the 2-FF synchronizer is valid.
- CNT_W, 8: phase counter width; must hold max(RESET_CYCLES, SETTLE_CYCLES).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a measurement; accepted only when busy=0.
- challenge  in  2*RESP_BITS  challenge word, latched on the accepted start.
- busy  out  1  high from the accepted start until the response handshake completes.
- resp  out  RESP_BITS  response word; stable while resp_valid=1.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- slice_iR  out  1  slice release; 0 forces the AND outputs low (reset), 1 lets the rings evaluate.
- slice_i1  out  1  challenge input, top half.
- slice_i2  out  1  challenge input, bottom half.
- slice_out1  in  1  asynchronous slice output (DA path).
- slice_out2  in  1  asynchronous slice output (CB path).

Behaviour:
- Reset values: busy=0, resp=0, resp_valid=0, slice_iR=0, slice_i1=0, slice_i2=0, FSM=IDLE, bit index=0, sync flops=0.
- Synchronizers: slice_out1 and slice_out2 each pass through a 2-FF synchronizer clocked every cycle. Raw slice outputs are never used combinationally.
- IDLE: slice_iR=0. When start=1, latch challenge, clear resp, set bit index=0, set busy=1, go to RST. start while busy=1 is ignored, with no queuing.
- RST: slice_iR=0. slice_i1=chal[2*idx] and slice_i2=chal[2*idx+1], registered and held through RST and EVAL. Stay exactly RESET_CYCLES cycles, then go to EVAL.
- EVAL: slice_iR=1. Stay exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: one cycle. slice_iR stays 1. Write resp[idx] = sync_out1 XOR sync_out2.
  - If idx = RESP_BITS-1, go to DONE.
  - Otherwise idx+1 and go to RST.
- DONE: slice_iR=0 and resp_valid=1. When resp_valid and resp_ready are both high in a cycle, clear resp_valid and busy and go to IDLE. resp holds its value until the next accepted start.
- Latency:
  - Each bit takes RESET_CYCLES+SETTLE_CYCLES+1 cycles.
  - resp_valid rises RESP_BITS*(RESET_CYCLES+SETTLE_CYCLES+1)+1 cycles after the clock edge that accepts start.
- resp_ready held high before DONE has no effect. A start in the same cycle as the DONE handshake is ignored, because busy is still 1 that cycle.
- Reset mid-operation: immediate return to the reset values. The partial response is discarded and the slice is forced into reset (iR=0).
- Challenge input changes after start are ignored; only the latched copy is used.
- Counters saturate-free. The phase counter reloads on every state entry; no wrap-around can occur within legal parameters.

Optional Feature:
- Macro: XPR_PUF_MAJORITY_EN.
- Defined:
  - Each response bit is evaluated 3 times (RST/EVAL/SAMPLE repeated with the same challenge pair).
  - A 2-bit per-bit vote counter accumulates the XOR samples. resp[idx] = 1 iff at least 2 of the 3 samples are 1.
  - Per-bit latency triples. resp_valid rises 3*RESP_BITS*(RESET_CYCLES+SETTLE_CYCLES+1)+1 cycles after start.
- Undefined: single evaluation per bit as described above. The vote logic is absent.

Test Plan:
- RESP_BITS=4, RESET_CYCLES=2, SETTLE_CYCLES=4; slice model ties out1=i1, out2=0; challenge=8'b01_00_01_01 (idx0=01, idx1=01, idx2=00, idx3=01) -> resp=4'b1011, resp_valid rises exactly 29 cycles after the start edge, busy=1 throughout.
- Same setup; check slice_iR waveform per bit -> 2 cycles low, 4 high, 1 high (SAMPLE), repeated 4 times; slice_i1/i2 match the challenge pair during each RST+EVAL window.
- Hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp stay stable; start pulses are ignored. Assert resp_ready -> resp_valid and busy drop the next cycle.
- Pulse start again mid-measurement (bit 2) with a different challenge -> no effect; the original response completes.
- Assert reset during EVAL of bit 1 -> slice_iR=0, busy=0, resp_valid=0 immediately (async). Next start runs a full fresh measurement.
- With XPR_PUF_MAJORITY_EN, slice model flips out1 on the 2nd of 3 evaluations only -> resp bit equals the majority value; latency is 85 cycles for the 4-bit configuration.
